ab_pulse_gen: RTL and testbench

Upstream stimulus stage for the delay-sequence checker. On a start command it drives one-cycle `a` pulses, each followed by a one-cycle `b` pulse exactly `gap` cycles later, for a programmed number of transactions. The checker downstream consumes `a`/`b` and raises its match when the spacing is correct. All outputs are registered.

---
 rtl/ab_pulse_gen.sv | 153 +++++++++++++++
 tb/tb_ab_pulse_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ab_pulse_gen.sv
// a/b stimulus generator for the delay-sequence checker: N transactions, b lags a by G cycles.
// Build option: define AB_PULSE_GEN_OVERLAP_EN for back-to-back a pulses tracked by a shift register.
module ab_pulse_gen #(
    parameter int GAP_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [GAP_W-1:0] gap,
    input  logic [CNT_W-1:0] count,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_WAIT, ST_FINISH} state_t;

    state_t           state, state_nxt;
    logic [GAP_W-1:0] g_q, g_nxt;
    logic [CNT_W-1:0] n_q, n_nxt;
    logic [CNT_W-1:0] sent_nxt;
    logic             a_nxt, b_nxt, busy_nxt, done_nxt;

`ifdef AB_PULSE_GEN_OVERLAP_EN
    localparam int DEPTH = 1 << GAP_W;
    logic [DEPTH-1:0] sh, sh_nxt;
    logic [CNT_W-1:0] issued, issued_nxt;
`else
    logic [GAP_W-1:0] cnt, cnt_nxt;
`endif

    always_comb begin
        state_nxt = state;
        g_nxt     = g_q;
        n_nxt     = n_q;
        sent_nxt  = sent;
`ifdef AB_PULSE_GEN_OVERLAP_EN
        issued_nxt = issued;
        sh_nxt     = '0;
`else
        cnt_nxt = cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (count != '0) begin
                        g_nxt     = gap;
                        n_nxt     = count;
                        sent_nxt  = '0;
`ifdef AB_PULSE_GEN_OVERLAP_EN
                        issued_nxt = '0;
`endif
                        state_nxt = ST_FIRE;
                    end else begin
                        state_nxt = ST_FINISH;
                    end
                end
            end
`ifdef AB_PULSE_GEN_OVERLAP_EN
            ST_FIRE, ST_WAIT: begin
                if (sent == n_q)
                    state_nxt = ST_FINISH;
                else if (state == ST_FIRE && issued != n_q)
                    state_nxt = ST_FIRE;
                else
                    state_nxt = ST_WAIT;
            end
`else
            ST_FIRE: begin
                if (g_q == '0)
                    state_nxt = (sent == n_q) ? ST_FINISH : ST_FIRE;
                else begin
                    cnt_nxt   = g_q;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // cnt==1 marks the cycle b is already high, so sent is up to date here
                if (cnt == GAP_W'(1))
                    state_nxt = (sent == n_q) ? ST_FINISH : ST_FIRE;
                else
                    cnt_nxt = cnt - GAP_W'(1);
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase

        if (stop && (state == ST_FIRE || state == ST_WAIT))
            state_nxt = ST_IDLE;

        a_nxt    = (state_nxt == ST_FIRE);
        busy_nxt = (state_nxt == ST_FIRE) || (state_nxt == ST_WAIT);
        done_nxt = (state_nxt == ST_FINISH);

`ifdef AB_PULSE_GEN_OVERLAP_EN
        // sh[j] holds a from j+1 cycles ago; cleared whenever no run is active
        b_nxt = 1'b0;
        if (busy_nxt) begin
            sh_nxt = {sh[DEPTH-2:0], a};
            if (g_nxt == '0)
                b_nxt = a_nxt;
            else if (g_nxt == GAP_W'(1))
                b_nxt = a;
            else
                b_nxt = sh[g_nxt - GAP_W'(2)];
        end
        issued_nxt = issued_nxt + CNT_W'(a_nxt);
`else
        b_nxt = ((state_nxt == ST_FIRE) && (g_nxt == '0)) ||
                ((state_nxt == ST_WAIT) && (cnt_nxt == GAP_W'(1)));
`endif
        sent_nxt = sent_nxt + CNT_W'(b_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            g_q   <= '0;
            n_q   <= '0;
            sent  <= '0;
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef AB_PULSE_GEN_OVERLAP_EN
            sh     <= '0;
            issued <= '0;
`else
            cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            g_q   <= g_nxt;
            n_q   <= n_nxt;
            sent  <= sent_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
`ifdef AB_PULSE_GEN_OVERLAP_EN
            sh     <= sh_nxt;
            issued <= issued_nxt;
`else
            cnt <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ab_pulse_gen.sv
// Randomized bench for ab_pulse_gen against a closed-form per-cycle schedule model.
module tb_ab_pulse_gen;

    localparam int GAP_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [GAP_W-1:0] gap = '0;
    logic [CNT_W-1:0] count = '0;
    logic             a, b, busy, done;
    logic [CNT_W-1:0] sent;

    int n_cmp = 0;
    int n_err = 0;

    ab_pulse_gen #(.GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .gap(gap), .count(count),
        .a(a), .b(b), .busy(busy), .done(done), .sent(sent)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Busy length of a run in cycles
    function automatic int run_len(input int g, input int n);
        if (n == 0) return 0;
`ifdef AB_PULSE_GEN_OVERLAP_EN
        return n + g;
`else
        return n * (g + 1);
`endif
    endfunction

    // Number of b pulses seen in cycles 1..t after the start edge
    function automatic int b_upto(input int t, input int g, input int n);
        int v;
`ifdef AB_PULSE_GEN_OVERLAP_EN
        v = t - g;
`else
        v = t / (g + 1);
`endif
        if (v < 0) v = 0;
        if (v > n) v = n;
        return v;
    endfunction

    // Expected outputs in cycle t (t=1 is the cycle after the start edge); sp>0 = stop sampled at end of cycle sp
    task automatic model(input int t, input int g, input int n, input int sp,
                         output int ea, output int eb, output int ebusy, output int edone, output int esent);
        int len;
        len   = run_len(g, n);
        ebusy = (t >= 1 && t <= len) ? 1 : 0;
        edone = (t == len + 1) ? 1 : 0;
        esent = b_upto(t, g, n);
        eb    = (b_upto(t, g, n) != b_upto(t - 1, g, n)) ? 1 : 0;
`ifdef AB_PULSE_GEN_OVERLAP_EN
        ea = (t >= 1 && t <= n) ? 1 : 0;
`else
        ea = (t >= 1 && (t - 1) % (g + 1) == 0 && (t - 1) / (g + 1) < n) ? 1 : 0;
`endif
        if (sp > 0 && t > sp) begin
            ea = 0; eb = 0; ebusy = 0; edone = 0;
            esent = b_upto(sp, g, n);
        end
    endtask

    task automatic run(input int g, input int n, input int sp, input bit noise);
        int len, last, ea, eb, ebusy, edone, esent;
        len  = run_len(g, n);
        last = (sp > 0) ? sp + 3 : len + 3;
        @(negedge clk);
        gap = GAP_W'(g); count = CNT_W'(n); start = 1'b1; stop = 1'b0;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            gap   = GAP_W'($urandom);
            model(t, g, n, sp, ea, eb, ebusy, edone, esent);
            check($sformatf("a g%0d n%0d t%0d", g, n, t), int'(a), ea);
            check($sformatf("b g%0d n%0d t%0d", g, n, t), int'(b), eb);
            check($sformatf("busy g%0d n%0d t%0d", g, n, t), int'(busy), ebusy);
            check($sformatf("done g%0d n%0d t%0d", g, n, t), int'(done), edone);
            if (n > 0)
                check($sformatf("sent g%0d n%0d t%0d", g, n, t), int'(sent), esent);
            if (sp > 0 && t == sp) stop = 1'b1;
            if (noise && t <= ((sp > 0) ? sp : len + 1) && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                count = CNT_W'($urandom_range(1, 255));
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int g, n, sp, len;
        #2;
        check("reset a", int'(a), 0);
        check("reset b", int'(b), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset sent", int'(sent), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(3, 1, 0, 1'b0);
        run(0, 3, 0, 1'b0);
        run(0, 0, 0, 1'b1);
        run(5, 4, 3, 1'b0);
        run(2, 3, 0, 1'b1);
        run(3, 4, 0, 1'b0);
        run(15, 2, 0, 1'b1);
        run(0, 255, 0, 1'b0);

        // start and stop together in IDLE: no run may begin
        @(negedge clk);
        gap = 4'd1; count = 8'd2; start = 1'b1; stop = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            check($sformatf("startstop busy t%0d", t), int'(busy), 0);
            check($sformatf("startstop a t%0d", t), int'(a), 0);
            check($sformatf("startstop done t%0d", t), int'(done), 0);
        end

        // asynchronous reset in the middle of a run
        @(negedge clk);
        gap = 4'd7; count = 8'd2; start = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrun busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrun a", int'(a), 0);
        check("midrun b", int'(b), 0);
        check("midrun busy", int'(busy), 0);
        check("midrun done", int'(done), 0);
        check("midrun sent", int'(sent), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 1, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            g   = $urandom_range(0, 15);
            n   = $urandom_range(0, 6);
            len = run_len(g, n);
            sp  = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
            run(g, n, sp, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
